// File: rtl/tag_rx_pkg.sv
// Shared encodings for the tag RX hop framer: control-stage states, header marker, framer FSM states.
package tag_rx_pkg;

    localparam logic [1:0] RX_INIT      = 2'b00;
    localparam logic [1:0] RX_LOC_SYNCH = 2'b01;
    localparam logic [1:0] RX_HOP_SYNCH = 2'b10;
    localparam logic [1:0] RX_HOP_RX    = 2'b11;

    localparam logic [15:0] HDR_MARKER = 16'hA5A5;

    typedef logic [1:0] frm_state_t;

    localparam frm_state_t ST_IDLE  = 2'd0;
    localparam frm_state_t ST_ACCUM = 2'd1;
    localparam frm_state_t ST_TRAIL = 2'd2;
    localparam frm_state_t ST_SKIP  = 2'd3;

endpackage

// File: rtl/tag_rx_hop_fifo.sv
// Synchronous FIFO for framer output words; tlast is stored alongside data and the head sits in a
// registered output stage. count covers every held entry, including the one in the output register.
module tag_rx_hop_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         wr_last,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_last,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   mem_count;
    logic            pop;
    logic            load;
    logic            wr_ok;

    assign pop       = rd_valid && rd_ready;
    assign mem_count = count - CW'(rd_valid);
    assign load      = (mem_count != '0) && (!rd_valid || pop);
    assign wr_ok     = wr_en && (mem_count != CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= {wr_last, wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Output register only advances when empty or being consumed, so it holds under backpressure.
            if (load) begin
                {rd_last, rd_data} <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
                rd_valid <= 1'b1;
            end else if (pop) begin
                rd_valid <= 1'b0;
            end
            count <= count + CW'(wr_ok) - CW'(pop);
        end
    end

endmodule

// File: rtl/tag_rx_hop_framer.sv
// Averages HOP_RX I/Q samples into words and frames each hop with a trailer (optional header when
// TAG_RX_HOP_FRAMER_HEADER_EN is defined).
module tag_rx_hop_framer
    import tag_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DECIM_LOG2 = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] irx_in,
    input  logic signed [DATA_WIDTH-1:0] qrx_in,
    input  logic [1:0]                   rx_state,
    output logic [2*DATA_WIDTH-1:0]      m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         m_tlast,
    output logic [7:0]                   hop_index,
    output logic                         overflow
);

    localparam int AW  = DATA_WIDTH + DECIM_LOG2;
    localparam int SCW = DECIM_LOG2 + 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int TW  = 2 * DATA_WIDTH;
    localparam logic [SCW-1:0] LAST_SAMPLE = SCW'((1 << DECIM_LOG2) - 1);
    localparam logic [CW-1:0]  DATA_LIMIT  = CW'(FIFO_DEPTH - 1);

    frm_state_t               state;
    logic [1:0]               rx_state_q;
    logic signed [AW-1:0]     acc_i;
    logic signed [AW-1:0]     acc_q;
    logic signed [AW-1:0]     sum_i;
    logic signed [AW-1:0]     sum_q;
    logic [DATA_WIDTH-1:0]    avg_i;
    logic [DATA_WIDTH-1:0]    avg_q;
    logic [SCW-1:0]           smp_cnt;
    logic [DATA_WIDTH-1:0]    word_cnt;
    logic                     pipe_valid;
    logic                     pipe_last;
    logic                     pipe_force;
    logic [TW-1:0]            pipe_data;
    logic [CW-1:0]            fifo_count;
    logic                     hop_start;
    logic                     push;
    logic                     drop;

    assign hop_start = (state == ST_IDLE) && (rx_state == RX_HOP_RX) && (rx_state_q != RX_HOP_RX);
    assign sum_i     = acc_i + AW'(irx_in);
    assign sum_q     = acc_q + AW'(qrx_in);
    assign avg_i     = DATA_WIDTH'(sum_i >>> DECIM_LOG2);
    assign avg_q     = DATA_WIDTH'(sum_q >>> DECIM_LOG2);

    // Headers and trailers always fit; data words must leave the last entry free for the trailer.
    assign push = pipe_valid && (pipe_force || (fifo_count < DATA_LIMIT));
    assign drop = pipe_valid && !push;

`ifdef TAG_RX_HOP_FRAMER_HEADER_EN
    logic hdr_room;
    assign hdr_room = (fifo_count + CW'(pipe_valid)) <= CW'(FIFO_DEPTH - 2);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            rx_state_q <= rx_state;
            acc_i      <= '0;
            acc_q      <= '0;
            smp_cnt    <= '0;
            word_cnt   <= '0;
            hop_index  <= '0;
            overflow   <= 1'b0;
            pipe_valid <= 1'b0;
            pipe_last  <= 1'b0;
            pipe_force <= 1'b0;
            pipe_data  <= '0;
        end else begin
            rx_state_q <= rx_state;
            pipe_valid <= 1'b0;
            pipe_last  <= 1'b0;
            pipe_force <= 1'b0;
            if (drop) begin
                overflow <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (hop_start) begin
                        hop_index <= hop_index + 8'd1;
                        acc_i     <= '0;
                        acc_q     <= '0;
                        smp_cnt   <= '0;
                        word_cnt  <= '0;
`ifdef TAG_RX_HOP_FRAMER_HEADER_EN
                        if (hdr_room) begin
                            state      <= ST_ACCUM;
                            pipe_valid <= 1'b1;
                            pipe_force <= 1'b1;
                            pipe_data  <= TW'({HDR_MARKER, 8'h00, hop_index + 8'd1});
                        end else begin
                            state    <= ST_SKIP;
                            overflow <= 1'b1;
                        end
`else
                        state <= ST_ACCUM;
`endif
                    end
                end
                ST_ACCUM: begin
                    if (rx_state != RX_HOP_RX) begin
                        state <= ST_TRAIL;
                    end else if (sample_valid) begin
                        if (smp_cnt == LAST_SAMPLE) begin
                            acc_i      <= '0;
                            acc_q      <= '0;
                            smp_cnt    <= '0;
                            word_cnt   <= word_cnt + 1'b1;
                            pipe_valid <= 1'b1;
                            pipe_data  <= {avg_i, avg_q};
                        end else begin
                            acc_i   <= sum_i;
                            acc_q   <= sum_q;
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                ST_TRAIL: begin
                    pipe_valid <= 1'b1;
                    pipe_last  <= 1'b1;
                    pipe_force <= 1'b1;
                    pipe_data  <= TW'({8'h00, hop_index, word_cnt});
                    state      <= ST_IDLE;
                end
                ST_SKIP: begin
                    if (rx_state != RX_HOP_RX) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    tag_rx_hop_fifo #(
        .WIDTH (TW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (push),
        .wr_data  (pipe_data),
        .wr_last  (pipe_last),
        .rd_valid (m_tvalid),
        .rd_ready (m_tready),
        .rd_data  (m_tdata),
        .rd_last  (m_tlast),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_tag_rx_hop_framer.sv
// Directed bench for tag_rx_hop_framer (default build, header disabled).
module tb_tag_rx_hop_framer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sample_valid;
    logic [15:0] irx_in;
    logic [15:0] qrx_in;
    logic [1:0]  rx_state;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [7:0]  hop_index;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic [32:0] q_out[$];

    tag_rx_hop_framer #(
        .DATA_WIDTH (16),
        .DECIM_LOG2 (4),
        .FIFO_DEPTH (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .irx_in       (irx_in),
        .qrx_in       (qrx_in),
        .rx_state     (rx_state),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .hop_index    (hop_index),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // A word seen valid and ready at the falling edge is accepted on the following rising edge.
    always @(negedge clk) begin
        if (reset_n && m_tvalid && m_tready) begin
            q_out.push_back({m_tlast, m_tdata});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input int n, input logic [15:0] i_val, input logic [15:0] q_val);
        for (int k = 0; k < n; k++) begin
            sample_valid = 1'b1;
            irx_in       = i_val;
            qrx_in       = q_val;
            tick(1);
        end
        sample_valid = 1'b0;
    endtask

    task automatic start_hop();
        rx_state = 2'b11;
        tick(1);
    endtask

    task automatic end_hop();
        rx_state     = 2'b00;
        sample_valid = 1'b0;
        tick(2);
    endtask

    initial begin
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        irx_in       = '0;
        qrx_in       = '0;
        rx_state     = 2'b00;
        m_tready     = 1'b1;
        tick(3);
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tlast", m_tlast, 1'b0);
        chk("rst_tdata", m_tdata, 32'h0);
        chk("rst_hop", hop_index, 8'd0);
        chk("rst_ovf", overflow, 1'b0);
        reset_n = 1'b1;
        tick(2);

        // Hop 1: two groups of I=100, Q=-3, with output latency checked on the first group.
        q_out.delete();
        start_hop();
        chk("hop1_index", hop_index, 8'd1);
        for (int k = 0; k < 32; k++) begin
            sample_valid = 1'b1;
            irx_in       = 16'd100;
            qrx_in       = 16'hFFFD;
            tick(1);
            if (k == 15 || k == 16) chk("lat_not_yet", m_tvalid, 1'b0);
            if (k == 17) begin
                chk("lat_valid", m_tvalid, 1'b1);
                chk("lat_word", m_tdata, 32'h0064FFFD);
            end
        end
        end_hop();
        tick(6);
        chk("h1_n", q_out.size(), 3);
        chk("h1_w0", q_out[0], {1'b0, 32'h0064FFFD});
        chk("h1_w1", q_out[1], {1'b0, 32'h0064FFFD});
        chk("h1_trl", q_out[2], {1'b1, 32'h00010002});
        chk("h1_ovf", overflow, 1'b0);

        // Hop 2: samples outside HOP_RX ignored; full-scale alternation floors to -1 without wrap.
        q_out.delete();
        rx_state = 2'b10;
        feed(5, 16'd1000, 16'd1000);
        start_hop();
        chk("hop2_index", hop_index, 8'd2);
        for (int k = 0; k < 16; k++) begin
            sample_valid = 1'b1;
            irx_in       = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
            qrx_in       = 16'h8000;
            tick(1);
            sample_valid = 1'b0;
            tick(1);
        end
        end_hop();
        tick(6);
        chk("h2_n", q_out.size(), 2);
        chk("h2_w0", q_out[0], {1'b0, 32'hFFFF8000});
        chk("h2_trl", q_out[1], {1'b1, 32'h00020001});

        // Hop 3 exits after 10 samples; hop 4 must start from cleared accumulators.
        q_out.delete();
        start_hop();
        feed(10, 16'd1000, 16'd1000);
        end_hop();
        tick(6);
        chk("h3_n", q_out.size(), 1);
        chk("h3_trl", q_out[0], {1'b1, 32'h00030000});
        q_out.delete();
        start_hop();
        feed(16, 16'hFFFF, 16'h0001);
        end_hop();
        tick(6);
        chk("h4_n", q_out.size(), 2);
        chk("h4_w0", q_out[0], {1'b0, 32'hFFFF0001});
        chk("h4_trl", q_out[1], {1'b1, 32'h00040001});

        // Hop 5: 20 groups under backpressure; 15 kept, trailer reserved.
        q_out.delete();
        m_tready = 1'b0;
        start_hop();
        feed(320, 16'd5, 16'hFFFB);
        chk("h5_hold_valid", m_tvalid, 1'b1);
        chk("h5_hold_data", m_tdata, 32'h0005FFFB);
        chk("h5_hold_last", m_tlast, 1'b0);
        chk("h5_ovf", overflow, 1'b1);
        end_hop();
        tick(4);
        chk("h5_stall_data", m_tdata, 32'h0005FFFB);
        m_tready = 1'b1;
        tick(25);
        chk("h5_n", q_out.size(), 16);
        chk("h5_w0", q_out[0], {1'b0, 32'h0005FFFB});
        chk("h5_w14", q_out[14], {1'b0, 32'h0005FFFB});
        chk("h5_trl", q_out[15], {1'b1, 32'h00050014});
        chk("h5_ovf_sticky", overflow, 1'b1);

        // Hops 6..256: index runs up to 255 then wraps to 0.
        for (int h = 6; h <= 256; h++) begin
            start_hop();
            chk("hop_seq", hop_index, h[7:0]);
            end_hop();
        end
        tick(6);

        // Reset mid-hop with three words buffered.
        q_out.delete();
        m_tready = 1'b0;
        start_hop();
        chk("h257_index", hop_index, 8'd1);
        feed(53, 16'd9, 16'd9);
        tick(3);
        chk("pre_rst_valid", m_tvalid, 1'b1);
        reset_n = 1'b0;
        tick(1);
        chk("mid_rst_valid", m_tvalid, 1'b0);
        chk("mid_rst_hop", hop_index, 8'd0);
        chk("mid_rst_ovf", overflow, 1'b0);
        chk("mid_rst_data", m_tdata, 32'h0);
        reset_n  = 1'b1;
        m_tready = 1'b1;
        tick(10);
        chk("post_rst_n", q_out.size(), 0);
        chk("post_rst_valid", m_tvalid, 1'b0);
        chk("post_rst_hop", hop_index, 8'd0);

        // A fresh transition into HOP_RX starts a clean hop.
        rx_state = 2'b00;
        tick(2);
        start_hop();
        chk("fresh_hop", hop_index, 8'd1);
        feed(16, 16'd3, 16'hFFFD);
        end_hop();
        tick(6);
        chk("fresh_n", q_out.size(), 2);
        chk("fresh_w0", q_out[0], {1'b0, 32'h0003FFFD});
        chk("fresh_trl", q_out[1], {1'b1, 32'h00010001});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
